// File: rtl/pong_if.sv
// Frame-rate control and game-state bundle between the Pong engine and its neighbours:
// timing/button inputs towards the engine, ball/paddle/score outputs towards the renderer.
interface pong_if;
    logic       frame_start;
    logic       btn_up;
    logic       btn_down;
    logic [9:0] ball_x;
    logic [9:0] ball_y;
    logic [9:0] paddle_x;
    logic [9:0] paddle_y;
    logic [7:0] hit_count;
    logic [7:0] miss_count;
    logic [1:0] game_state;
    logic       miss_flash;

    modport master (
        output frame_start, btn_up, btn_down,
        input  ball_x, ball_y, paddle_x, paddle_y,
        input  hit_count, miss_count, game_state, miss_flash
    );

    modport slave (
        input  frame_start, btn_up, btn_down,
        output ball_x, ball_y, paddle_x, paddle_y,
        output hit_count, miss_count, game_state, miss_flash
    );
endinterface

// File: rtl/pong_engine.sv
// Per-frame Pong state engine: serve/play/miss sequencing, ball motion with wall and
// paddle collisions, button-driven paddle and saturating hit/miss counters.
module pong_engine #(
    parameter int H_RES        = 640,
    parameter int V_RES        = 480,
    parameter int BALL_SIZE    = 8,
    parameter int BALL_SPEED   = 2,
    parameter int PADDLE_X     = 16,
    parameter int PADDLE_W     = 8,
    parameter int PADDLE_H     = 64,
    parameter int PADDLE_SPEED = 4,
    parameter int SERVE_FRAMES = 60,
    parameter int MISS_FRAMES  = 30
) (
    input logic   clk_i,
    input logic   reset_i,
    pong_if.slave bus
);
    typedef enum logic [1:0] {
        ST_SERVE = 2'd0,
        ST_PLAY  = 2'd1,
        ST_MISS  = 2'd2
    } state_e;

    localparam logic [9:0] BALL_CX    = 10'((H_RES - BALL_SIZE) / 2);
    localparam logic [9:0] BALL_CY    = 10'((V_RES - BALL_SIZE) / 2);
    localparam logic [9:0] PAD_CY     = 10'((V_RES - PADDLE_H) / 2);
    localparam logic [9:0] PAD_MAX    = 10'(V_RES - PADDLE_H);
    localparam logic [9:0] PAD_STEP   = 10'(PADDLE_SPEED);
    localparam logic [9:0] X_MAX      = 10'(H_RES - BALL_SIZE);
    localparam logic [9:0] Y_MAX      = 10'(V_RES - BALL_SIZE);
    localparam logic [9:0] PAD_EDGE   = 10'(PADDLE_X + PADDLE_W);
    localparam logic signed [10:0] STEP_S     = 11'(BALL_SPEED);
    localparam logic signed [10:0] X_MAX_S    = 11'(H_RES - BALL_SIZE);
    localparam logic signed [10:0] Y_MAX_S    = 11'(V_RES - BALL_SIZE);
    localparam logic signed [10:0] PAD_EDGE_S = 11'(PADDLE_X + PADDLE_W);
    localparam logic signed [10:0] BALL_SZ_S  = 11'(BALL_SIZE);
    localparam logic signed [10:0] PAD_H_S    = 11'(PADDLE_H);
    localparam logic [5:0] SERVE_LAST = 6'(SERVE_FRAMES - 1);
    localparam logic [5:0] MISS_LAST  = 6'(MISS_FRAMES - 1);

    state_e     state_q;
    logic [9:0] ball_x_q, ball_y_q, paddle_y_q;
    logic [7:0] hit_count_q, miss_count_q;
    logic [5:0] frame_cnt_q;
    logic       vx_neg_q, vy_neg_q, serve_neg_q, miss_flash_q;
    logic [1:0] up_sync_q, down_sync_q;

    logic signed [10:0] nx_d, ny_d, pad_top_s;
    logic [9:0]         paddle_d;
    logic               hit_s, miss_s;

    // Next-position arithmetic, paddle-overlap test and paddle motion for the coming frame.
    always_comb begin
        nx_d      = $signed({1'b0, ball_x_q}) + (vx_neg_q ? -STEP_S : STEP_S);
        ny_d      = $signed({1'b0, ball_y_q}) + (vy_neg_q ? -STEP_S : STEP_S);
        pad_top_s = $signed({1'b0, paddle_y_q});
        hit_s     = vx_neg_q && (nx_d <= PAD_EDGE_S) && ((ny_d + BALL_SZ_S) > pad_top_s)
                    && (ny_d < (pad_top_s + PAD_H_S));
        miss_s    = vx_neg_q && (nx_d <= 11'sd0) && !hit_s;
        if (up_sync_q[1] && !down_sync_q[1]) begin
            paddle_d = (paddle_y_q < PAD_STEP) ? 10'd0 : paddle_y_q - PAD_STEP;
        end else if (down_sync_q[1] && !up_sync_q[1]) begin
            paddle_d = (paddle_y_q > PAD_MAX - PAD_STEP) ? PAD_MAX : paddle_y_q + PAD_STEP;
        end else begin
            paddle_d = paddle_y_q;
        end
    end

    // Button synchronisers plus the per-frame game FSM and all registered outputs.
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            up_sync_q    <= 2'b00;
            down_sync_q  <= 2'b00;
            state_q      <= ST_SERVE;
            ball_x_q     <= BALL_CX;
            ball_y_q     <= BALL_CY;
            paddle_y_q   <= PAD_CY;
            hit_count_q  <= 8'd0;
            miss_count_q <= 8'd0;
            frame_cnt_q  <= 6'd0;
            vx_neg_q     <= 1'b0;
            vy_neg_q     <= 1'b0;
            serve_neg_q  <= 1'b0;
            miss_flash_q <= 1'b0;
        end else begin
            up_sync_q   <= {up_sync_q[0], bus.btn_up};
            down_sync_q <= {down_sync_q[0], bus.btn_down};
            if (bus.frame_start) begin
                paddle_y_q <= paddle_d;
                case (state_q)
                    ST_SERVE: begin
                        ball_x_q <= BALL_CX;
                        ball_y_q <= BALL_CY;
                        if (frame_cnt_q == SERVE_LAST) begin
                            state_q     <= ST_PLAY;
                            vx_neg_q    <= serve_neg_q;
                            vy_neg_q    <= 1'b0;
                            serve_neg_q <= ~serve_neg_q;
                            frame_cnt_q <= 6'd0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 6'd1;
                        end
                    end
                    ST_PLAY: begin
                        // Vertical and horizontal outcomes are independent so corners apply both.
                        if (ny_d <= 11'sd0) begin
                            ball_y_q <= 10'd0;
                            vy_neg_q <= 1'b0;
                        end else if (ny_d >= Y_MAX_S) begin
                            ball_y_q <= Y_MAX;
                            vy_neg_q <= 1'b1;
                        end else begin
                            ball_y_q <= ny_d[9:0];
                        end
                        if (hit_s) begin
                            ball_x_q <= PAD_EDGE;
                            vx_neg_q <= 1'b0;
                            if (hit_count_q != 8'hFF) hit_count_q <= hit_count_q + 8'd1;
                        end else if (miss_s) begin
                            ball_x_q     <= 10'd0;
                            state_q      <= ST_MISS;
                            miss_flash_q <= 1'b1;
                            frame_cnt_q  <= 6'd0;
                            if (miss_count_q != 8'hFF) miss_count_q <= miss_count_q + 8'd1;
                        end else if (nx_d >= X_MAX_S) begin
                            ball_x_q <= X_MAX;
                            vx_neg_q <= 1'b1;
                        end else begin
                            ball_x_q <= nx_d[9:0];
                        end
                    end
                    ST_MISS: begin
                        if (frame_cnt_q == MISS_LAST) begin
                            state_q      <= ST_SERVE;
                            ball_x_q     <= BALL_CX;
                            ball_y_q     <= BALL_CY;
                            frame_cnt_q  <= 6'd0;
                            miss_flash_q <= 1'b0;
                        end else begin
                            frame_cnt_q <= frame_cnt_q + 6'd1;
                        end
                    end
                    default: begin
                        state_q      <= ST_SERVE;
                        ball_x_q     <= BALL_CX;
                        ball_y_q     <= BALL_CY;
                        frame_cnt_q  <= 6'd0;
                        miss_flash_q <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign bus.ball_x     = ball_x_q;
    assign bus.ball_y     = ball_y_q;
    assign bus.paddle_x   = 10'(PADDLE_X);
    assign bus.paddle_y   = paddle_y_q;
    assign bus.hit_count  = hit_count_q;
    assign bus.miss_count = miss_count_q;
    assign bus.game_state = state_q;
    assign bus.miss_flash = miss_flash_q;
endmodule
